// File: rtl/ftq_pd_pkg.sv
// Shared types and sizing for the FTQ predecode writeback path.
package ftq_pd_pkg;

    localparam int FTQ_SIZE = 64;
    localparam int IDX_W    = 6;
    localparam int PRED_W   = 16;
    localparam int VADDR_W  = 50;
    localparam int DEPTH    = 2;
    localparam int OFF_W    = $clog2(PRED_W);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);

    // Per-slot control-flow type encoding from predecode
    localparam logic [1:0] BR_NONE   = 2'd0;
    localparam logic [1:0] BR_BRANCH = 2'd1;
    localparam logic [1:0] BR_JAL    = 2'd2;
    localparam logic [1:0] BR_JALR   = 2'd3;

    // Compressed FTQ pd entry as stored in the memory
    typedef struct packed {
        logic [PRED_W-1:0]  brMask;
        logic               jmpInfo_valid;
        logic [2:0]         jmpInfo_bits;   // {isRet, isCall, isJalr}
        logic [OFF_W-1:0]   jmpOffset;
        logic [VADDR_W-1:0] jalTarget;
        logic [PRED_W-1:0]  rvcMask;
    } pd_entry_t;

    // Circular pointer advance for the small writeback FIFO
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/ftq_pd_pack.sv
// Combinational packer: per-slot predecode vectors into one pd entry.
module ftq_pd_pack
    import ftq_pd_pkg::*;
(
    input  logic [PRED_W-1:0]   i_pd_valid,
    input  logic [PRED_W-1:0]   i_pd_isRVC,
    input  logic [PRED_W-1:0]   i_pd_isCall,
    input  logic [PRED_W-1:0]   i_pd_isRet,
    input  logic [2*PRED_W-1:0] i_pd_brType,
    input  logic [PRED_W-1:0]   i_instrRange,
    input  logic [VADDR_W-1:0]  i_jalTarget,
    output pd_entry_t           o_entry
);

    logic [PRED_W-1:0] w_q;
    logic [1:0]        w_bt;

    // Walk slots high to low so the lowest jump candidate is the last writer
    always_comb begin
        w_q     = i_pd_valid & i_instrRange;
        w_bt    = BR_NONE;
        o_entry = '0;
        for (int i = PRED_W - 1; i >= 0; i--) begin
            w_bt = i_pd_brType[2*i +: 2];
            o_entry.brMask[i] = w_q[i] & (w_bt == BR_BRANCH);
            if (w_q[i] && (w_bt == BR_JAL || w_bt == BR_JALR)) begin
                o_entry.jmpInfo_valid = 1'b1;
                o_entry.jmpOffset     = OFF_W'(i);
                o_entry.jmpInfo_bits  = {i_pd_isRet[i], i_pd_isCall[i], (w_bt == BR_JALR)};
            end
        end
        o_entry.rvcMask   = i_pd_isRVC;
        o_entry.jalTarget = i_jalTarget;
    end

endmodule

// File: rtl/ftq_pd_wb_writer.sv
// IFU predecode writeback -> FTQ pd memory write port, with a small FIFO,
// a per-entry written bitmap and a sticky duplicate-write flag.
module ftq_pd_wb_writer
    import ftq_pd_pkg::*;
(
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_wb_valid,
    output logic                 o_wb_ready,
    input  logic [IDX_W-1:0]     i_wb_ftqIdx,
    input  logic [PRED_W-1:0]    i_wb_pd_valid,
    input  logic [PRED_W-1:0]    i_wb_pd_isRVC,
    input  logic [PRED_W-1:0]    i_wb_pd_isCall,
    input  logic [PRED_W-1:0]    i_wb_pd_isRet,
    input  logic [2*PRED_W-1:0]  i_wb_pd_brType,
    input  logic [PRED_W-1:0]    i_wb_instrRange,
    input  logic [VADDR_W-1:0]   i_wb_jalTarget,
    input  logic                 i_wr_hold,
    input  logic                 i_flush_valid,
    input  logic                 i_clr_valid,
    input  logic [IDX_W-1:0]     i_clr_idx,
    output logic                 o_mem_wen,
    output logic [IDX_W-1:0]     o_mem_waddr,
    output logic [PRED_W-1:0]    o_mem_wdata_brMask,
    output logic [PRED_W-1:0]    o_mem_wdata_rvcMask,
    output logic                 o_mem_wdata_jmpInfo_valid,
    output logic [2:0]           o_mem_wdata_jmpInfo_bits,
    output logic [3:0]           o_mem_wdata_jmpOffset,
    output logic [VADDR_W-1:0]   o_mem_wdata_jalTarget,
    output logic [FTQ_SIZE-1:0]  o_entry_written,
    output logic                 o_dup_wr_err
);

    pd_entry_t          w_pack;
    pd_entry_t          w_head;
    logic               w_push;
    logic               w_pop;

    logic [IDX_W-1:0]   r_idx  [DEPTH];
    pd_entry_t          r_data [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [FTQ_SIZE-1:0] r_written;
    logic               r_dup;

    ftq_pd_pack u_pack (
        .i_pd_valid   (i_wb_pd_valid),
        .i_pd_isRVC   (i_wb_pd_isRVC),
        .i_pd_isCall  (i_wb_pd_isCall),
        .i_pd_isRet   (i_wb_pd_isRet),
        .i_pd_brType  (i_wb_pd_brType),
        .i_instrRange (i_wb_instrRange),
        .i_jalTarget  (i_wb_jalTarget),
        .o_entry      (w_pack)
    );

    // Ready depends only on registered occupancy, so a same-cycle pop
    // cannot open a slot for the producer.
    assign o_wb_ready = i_reset & (r_count < CNT_W'(DEPTH));
    assign w_push     = i_wb_valid & o_wb_ready & ~i_flush_valid;
    assign w_pop      = (r_count != '0) & ~i_wr_hold & ~i_flush_valid;

    assign w_head                    = r_data[r_rptr];
    assign o_mem_wen                 = w_pop;
    assign o_mem_waddr               = r_idx[r_rptr];
    assign o_mem_wdata_brMask        = w_head.brMask;
    assign o_mem_wdata_rvcMask       = w_head.rvcMask;
    assign o_mem_wdata_jmpInfo_valid = w_head.jmpInfo_valid;
    assign o_mem_wdata_jmpInfo_bits  = w_head.jmpInfo_bits;
    assign o_mem_wdata_jmpOffset     = w_head.jmpOffset;
    assign o_mem_wdata_jalTarget     = w_head.jalTarget;
    assign o_entry_written           = r_written;
    assign o_dup_wr_err              = r_dup;

    // FIFO storage, pointers and occupancy; flush only empties the queue
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_idx[k]  <= '0;
                r_data[k] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_idx[r_wptr]  <= i_wb_ftqIdx;
                r_data[r_wptr] <= w_pack;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Written bitmap: the set is issued last so it wins over a same-index clear
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_written <= '0;
        end else begin
            if (i_clr_valid) begin
                r_written[i_clr_idx] <= 1'b0;
            end
            if (w_pop) begin
                r_written[o_mem_waddr] <= 1'b1;
            end
        end
    end

    // Sticky duplicate-write flag, checked against the pre-update bitmap
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_dup <= 1'b0;
        end else if (w_pop && r_written[o_mem_waddr]) begin
            r_dup <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ftq_pd_wb_writer.sv
// Self-checking bench for ftq_pd_wb_writer: vector table + scoreboard.
module tb_ftq_pd_wb_writer;
    import ftq_pd_pkg::*;

    logic                 clk = 1'b0;
    logic                 i_reset, i_wb_valid, i_wr_hold, i_flush_valid, i_clr_valid;
    logic [IDX_W-1:0]     i_wb_ftqIdx, i_clr_idx;
    logic [PRED_W-1:0]    i_wb_pd_valid, i_wb_pd_isRVC, i_wb_pd_isCall, i_wb_pd_isRet, i_wb_instrRange;
    logic [2*PRED_W-1:0]  i_wb_pd_brType;
    logic [VADDR_W-1:0]   i_wb_jalTarget;
    logic                 o_wb_ready, o_mem_wen, o_mem_wdata_jmpInfo_valid, o_dup_wr_err;
    logic [IDX_W-1:0]     o_mem_waddr;
    logic [PRED_W-1:0]    o_mem_wdata_brMask, o_mem_wdata_rvcMask;
    logic [2:0]           o_mem_wdata_jmpInfo_bits;
    logic [3:0]           o_mem_wdata_jmpOffset;
    logic [VADDR_W-1:0]   o_mem_wdata_jalTarget;
    logic [FTQ_SIZE-1:0]  o_entry_written;

    always #5 clk = ~clk;

    ftq_pd_wb_writer dut (
        .i_clock(clk), .i_reset(i_reset), .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
        .i_wb_ftqIdx(i_wb_ftqIdx), .i_wb_pd_valid(i_wb_pd_valid), .i_wb_pd_isRVC(i_wb_pd_isRVC),
        .i_wb_pd_isCall(i_wb_pd_isCall), .i_wb_pd_isRet(i_wb_pd_isRet), .i_wb_pd_brType(i_wb_pd_brType),
        .i_wb_instrRange(i_wb_instrRange), .i_wb_jalTarget(i_wb_jalTarget), .i_wr_hold(i_wr_hold),
        .i_flush_valid(i_flush_valid), .i_clr_valid(i_clr_valid), .i_clr_idx(i_clr_idx),
        .o_mem_wen(o_mem_wen), .o_mem_waddr(o_mem_waddr), .o_mem_wdata_brMask(o_mem_wdata_brMask),
        .o_mem_wdata_rvcMask(o_mem_wdata_rvcMask), .o_mem_wdata_jmpInfo_valid(o_mem_wdata_jmpInfo_valid),
        .o_mem_wdata_jmpInfo_bits(o_mem_wdata_jmpInfo_bits), .o_mem_wdata_jmpOffset(o_mem_wdata_jmpOffset),
        .o_mem_wdata_jalTarget(o_mem_wdata_jalTarget), .o_entry_written(o_entry_written),
        .o_dup_wr_err(o_dup_wr_err)
    );

    typedef struct {
        logic [IDX_W-1:0]    idx;
        logic [PRED_W-1:0]   pd_valid, range_m, isRVC, isCall, isRet;
        logic [2*PRED_W-1:0] brType;
        logic [VADDR_W-1:0]  tgt;
        pd_entry_t           exp;
    } vec_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        pd_entry_t        e;
    } sb_t;

    int        checks = 0;
    int        failures = 0;
    sb_t       sb_q[$];
    sb_t       cur;
    vec_t      vt[6];
    pd_entry_t got;

    function automatic vec_t mk(input logic [IDX_W-1:0] idx, input logic [PRED_W-1:0] pv, rg,
                                input logic [2*PRED_W-1:0] bt, input logic [PRED_W-1:0] rvc, cl, rt,
                                input logic [VADDR_W-1:0] tgt, input logic [PRED_W-1:0] e_br,
                                input logic e_jv, input logic [2:0] e_jb, input logic [3:0] e_off);
        vec_t v;
        v.idx = idx; v.pd_valid = pv; v.range_m = rg; v.brType = bt;
        v.isRVC = rvc; v.isCall = cl; v.isRet = rt; v.tgt = tgt;
        v.exp.brMask = e_br; v.exp.jmpInfo_valid = e_jv; v.exp.jmpInfo_bits = e_jb;
        v.exp.jmpOffset = e_off; v.exp.jalTarget = tgt; v.exp.rvcMask = rvc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] g, input logic [127:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, g, e);
        end
    endtask

    task automatic drive(input vec_t v);
        i_wb_valid = 1'b1; i_wb_ftqIdx = v.idx; i_wb_pd_valid = v.pd_valid;
        i_wb_instrRange = v.range_m; i_wb_pd_brType = v.brType; i_wb_pd_isRVC = v.isRVC;
        i_wb_pd_isCall = v.isCall; i_wb_pd_isRet = v.isRet; i_wb_jalTarget = v.tgt;
        cur.idx = v.idx; cur.e = v.exp;
    endtask

    task automatic drive_plain(input logic [IDX_W-1:0] idx);
        drive(mk(idx, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 3'b0, 4'd0));
    endtask

    // Mid-cycle: score any memory write, then record any accepted writeback
    task automatic sample();
        sb_t e;
        @(negedge clk);
        if (o_mem_wen) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write got waddr=%0d required no write", o_mem_waddr);
            end else begin
                e = sb_q.pop_front();
                got.brMask = o_mem_wdata_brMask; got.jmpInfo_valid = o_mem_wdata_jmpInfo_valid;
                got.jmpInfo_bits = o_mem_wdata_jmpInfo_bits; got.jmpOffset = o_mem_wdata_jmpOffset;
                got.jalTarget = o_mem_wdata_jalTarget; got.rvcMask = o_mem_wdata_rvcMask;
                chk("wr_addr", 128'(o_mem_waddr), 128'(e.idx));
                chk("wr_data", 128'(got), 128'(e.e));
            end
        end
        if (!i_reset || i_flush_valid) sb_q.delete();
        else if (i_wb_valid && o_wb_ready) sb_q.push_back(cur);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b0; i_wr_hold = 1'b0; i_flush_valid = 1'b0; i_clr_valid = 1'b0; i_clr_idx = '0;
        drive_plain(6'd0);

        // Reset held with valid asserted
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("rst_ready", 128'(o_wb_ready), 128'(0));
            chk("rst_wen", 128'(o_mem_wen), 128'(0));
            chk("rst_written", 128'(o_entry_written), 128'(0));
            chk("rst_wdata", 128'({o_mem_wdata_brMask, o_mem_wdata_jalTarget, o_mem_wdata_jmpOffset}), 128'(0));
            adv();
        end
        i_reset = 1'b1; i_wb_valid = 1'b0;
        sample();
        chk("rel_ready", 128'(o_wb_ready), 128'(1));
        adv();

        // Packing table, sent back to back
        vt[0] = mk(6'd7, 16'hFFFF, 16'h00FF, 32'h0008_0C40, 16'hA5A5, 16'h0000, 16'h0020,
                   50'h1_2345_6789_ABCD, 16'h0008, 1'b1, 3'b101, 4'd5);
        vt[1] = mk(6'd10, 16'hFFFF, 16'hFFFF, 32'h0, 16'h0F0F, 16'hFFFF, 16'hFFFF,
                   50'h0, 16'h0000, 1'b0, 3'b000, 4'd0);
        vt[2] = mk(6'd11, 16'hF0F0, 16'hFF00, 32'h5555_5555, 16'h0000, 16'h0000, 16'h0000,
                   50'h3_FFFF_FFFF_FFFF, 16'hF000, 1'b0, 3'b000, 4'd0);
        vt[3] = mk(6'd12, 16'h8000, 16'h8000, 32'h8000_0030, 16'h1234, 16'h8000, 16'h0004,
                   50'h2_0000_0000_0001, 16'h0000, 1'b1, 3'b010, 4'd15);
        vt[4] = mk(6'd13, 16'h0003, 16'h0003, 32'h0000_0007, 16'h0001, 16'h0001, 16'h0001,
                   50'h0_0000_DEAD_BEEF, 16'h0002, 1'b1, 3'b111, 4'd0);
        vt[5] = mk(6'd63, 16'hFFFF, 16'h000F, 32'h0000_0210, 16'h8001, 16'h0010, 16'h0000,
                   50'h1_5555_AAAA_5555, 16'h0004, 1'b0, 3'b000, 4'd0);
        for (int v = 0; v < 6; v++) begin
            drive(vt[v]);
            sample();
            chk("tp_ready", 128'(o_wb_ready), 128'(1));
            if (v > 0) chk("tp_wen", 128'(o_mem_wen), 128'(1));
            adv();
        end
        i_wb_valid = 1'b0;
        sample(); adv();
        sample();
        chk("tbl_drained", 128'(sb_q.size()), 128'(0));
        chk("tbl_bitmap", 128'(o_entry_written), 128'(64'h8000_0000_0000_3C80));
        chk("tbl_dup", 128'(o_dup_wr_err), 128'(0));
        adv();

        // Backpressure under hold
        i_wr_hold = 1'b1;
        drive_plain(6'd1); sample();
        chk("bp_ready1", 128'(o_wb_ready), 128'(1)); chk("bp_hold_wen", 128'(o_mem_wen), 128'(0)); adv();
        drive_plain(6'd2); sample();
        chk("bp_ready2", 128'(o_wb_ready), 128'(1)); adv();
        drive_plain(6'd3); sample();
        chk("bp_full_ready", 128'(o_wb_ready), 128'(0)); chk("bp_hold_wen2", 128'(o_mem_wen), 128'(0)); adv();
        i_wr_hold = 1'b0; sample();
        chk("bp_full_pop_ready", 128'(o_wb_ready), 128'(0)); chk("bp_wen_a", 128'(o_mem_wen), 128'(1)); adv();
        sample();
        chk("bp_ready3", 128'(o_wb_ready), 128'(1)); chk("bp_wen_b", 128'(o_mem_wen), 128'(1)); adv();
        i_wb_valid = 1'b0; sample();
        chk("bp_wen_c", 128'(o_mem_wen), 128'(1)); adv();
        sample();
        chk("bp_idle", 128'(o_mem_wen), 128'(0));
        chk("bp_bits", 128'(o_entry_written[3:1]), 128'(3'b111)); adv();

        // Flush with two buffered and one incoming
        i_wr_hold = 1'b1;
        drive_plain(6'd5); sample(); adv();
        drive_plain(6'd6); sample(); adv();
        drive_plain(6'd9); i_wr_hold = 1'b0; i_flush_valid = 1'b1; sample();
        chk("fl_wen", 128'(o_mem_wen), 128'(0)); adv();
        i_flush_valid = 1'b0; i_wb_valid = 1'b0; sample();
        chk("fl_ready", 128'(o_wb_ready), 128'(1)); chk("fl_wen_after", 128'(o_mem_wen), 128'(0)); adv();
        for (int c = 0; c < 3; c++) begin sample(); adv(); end
        sample();
        chk("fl_bits", 128'({o_entry_written[9], o_entry_written[6], o_entry_written[5]}), 128'(0));
        chk("fl_bits_kept", 128'(o_entry_written[7]), 128'(1));
        adv();

        // Bitmap set/clear/duplicate
        drive_plain(6'd4); sample(); adv();
        i_wb_valid = 1'b0; sample(); adv();
        sample();
        chk("bm_set", 128'(o_entry_written[4]), 128'(1)); chk("bm_dup0", 128'(o_dup_wr_err), 128'(0)); adv();
        drive_plain(6'd4); sample(); adv();
        i_wb_valid = 1'b0; i_clr_valid = 1'b1; i_clr_idx = 6'd4; sample();
        chk("bm_setclr_wen", 128'(o_mem_wen), 128'(1)); adv();
        i_clr_valid = 1'b0; sample();
        chk("bm_set_wins", 128'(o_entry_written[4]), 128'(1)); chk("bm_dup1", 128'(o_dup_wr_err), 128'(1)); adv();
        i_clr_valid = 1'b1; i_clr_idx = 6'd4; sample(); adv();
        i_clr_valid = 1'b0; sample();
        chk("bm_clr", 128'(o_entry_written[4]), 128'(0)); chk("bm_dup_sticky", 128'(o_dup_wr_err), 128'(1));
        chk("bm_other", 128'(o_entry_written[63]), 128'(1)); adv();

        // Reset while an entry is buffered
        i_wr_hold = 1'b1; drive_plain(6'd30); sample(); adv();
        i_wb_valid = 1'b0; i_reset = 1'b0; sample(); adv();
        i_reset = 1'b1; i_wr_hold = 1'b0;
        for (int c = 0; c < 3; c++) begin sample(); adv(); end
        sample();
        chk("mr_written", 128'(o_entry_written), 128'(0));
        chk("mr_dup", 128'(o_dup_wr_err), 128'(0));
        chk("mr_ready", 128'(o_wb_ready), 128'(1));
        chk("end_sb_empty", 128'(sb_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
